// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle for logic_unit_pipe
interface logic_unit_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_IN*WIDTH-1:0]  in_data;
  logic [2:0]               in_op;
  logic                     in_chain;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_err;
  logic [CNT_W-1:0]         txn_count;

  modport slave (
    input  in_valid, in_data, in_op, in_chain, out_ready,
    output in_ready, out_valid, out_data, out_err, txn_count
  );

  modport master (
    output in_valid, in_data, in_op, in_chain, out_ready,
    input  in_ready, out_valid, out_data, out_err, txn_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - N-operand bitwise logic unit with chaining and a 2-entry result buffer
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_unit_pipe_if.slave      bus
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  logic [WIDTH-1:0] res;
  logic             res_err;

  // The buffer is a head register plus one tail slot; tail_v alone means full.
  logic [WIDTH-1:0] head_data;
  logic             head_err;
  logic             head_v;
  logic [WIDTH-1:0] tail_data;
  logic             tail_err;
  logic             tail_v;
  logic [CNT_W-1:0] txn;

  logic push;
  logic pop;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_r = and_r & bus.in_data[k*WIDTH +: WIDTH];
      or_r  = or_r  | bus.in_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ bus.in_data[k*WIDTH +: WIDTH];
    end
    if (bus.in_chain) begin
      and_r = and_r & acc;
      or_r  = or_r  | acc;
      xor_r = xor_r ^ acc;
    end
    res     = '0;
    res_err = 1'b0;
    case (bus.in_op)
      3'b000:  res = and_r;
      3'b001:  res = or_r;
      3'b010:  res = xor_r;
      3'b011:  res = ~and_r;
      3'b100:  res = ~or_r;
      3'b101:  res = ~xor_r;
      3'b110:  res = {{(WIDTH-1){1'b0}}, ^xor_r};
      default: res_err = 1'b1;
    endcase
  end

  assign push = bus.in_valid && !tail_v;
  assign pop  = head_v && bus.out_ready;

  assign bus.in_ready  = !tail_v;
  assign bus.out_valid = head_v;
  assign bus.out_data  = head_data;
  assign bus.out_err   = head_err;
  assign bus.txn_count = txn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      head_data <= '0;
      head_err  <= 1'b0;
      head_v    <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
      tail_v    <= 1'b0;
      txn       <= '0;
    end else begin
      if (push && !res_err)
        acc <= res;
      if (pop)
        txn <= txn + CNT_W'(1);
      // A pop while full never coincides with a push because in_ready is low.
      if (pop) begin
        if (tail_v) begin
          head_data <= tail_data;
          head_err  <= tail_err;
          tail_v    <= 1'b0;
        end else if (push) begin
          head_data <= res;
          head_err  <= res_err;
        end else begin
          head_v <= 1'b0;
        end
      end else if (push) begin
        if (!head_v) begin
          head_data <= res;
          head_err  <= res_err;
          head_v    <= 1'b1;
        end else begin
          tail_data <= res;
          tail_err  <= res_err;
          tail_v    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic_unit_pipe_if #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) bus ();

  logic_unit_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] x0, input logic [7:0] x1,
                       input logic [2:0] op, input logic chain);
    bus.in_valid = v;
    bus.in_data  = {x1, x0};
    bus.in_op    = op;
    bus.in_chain = chain;
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_txn", bus.txn_count, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);

    // AND then NOR, streaming with out_ready high
    bus.out_ready = 1'b1;
    drive(1'b1, 8'hF0, 8'h3C, 3'b000, 1'b0);
    tick();
    check("and_valid", bus.out_valid, 1);
    check("and_data", bus.out_data, 8'h30);
    drive(1'b1, 8'h0F, 8'h30, 3'b100, 1'b0);
    tick();
    check("nor_data", bus.out_data, 8'hC0);
    check("nor_txn", bus.txn_count, 1);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    check("idle1_valid", bus.out_valid, 0);
    check("idle1_txn", bus.txn_count, 2);

    // chain sequence, acc kept across illegal op
    drive(1'b1, 8'h01, 8'h02, 3'b001, 1'b0);
    tick();
    check("chain_or", bus.out_data, 8'h03);
    drive(1'b1, 8'h10, 8'h00, 3'b010, 1'b1);
    tick();
    check("chain_xor", bus.out_data, 8'h13);
    check("chain_xor_err", bus.out_err, 0);
    drive(1'b1, 8'hAA, 8'h55, 3'b111, 1'b0);
    tick();
    check("illegal_data", bus.out_data, 8'h00);
    check("illegal_err", bus.out_err, 1);
    drive(1'b1, 8'hFF, 8'hFF, 3'b000, 1'b1);
    tick();
    check("chain_and", bus.out_data, 8'h13);
    check("chain_and_err", bus.out_err, 0);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    check("idle2_txn", bus.txn_count, 6);

    // parity
    drive(1'b1, 8'h07, 8'h00, 3'b110, 1'b0);
    tick();
    check("parity_07", bus.out_data, 8'h01);
    drive(1'b1, 8'h03, 8'h00, 3'b110, 1'b0);
    tick();
    check("parity_03", bus.out_data, 8'h00);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    check("idle3_txn", bus.txn_count, 8);

    // backpressure: fill both entries, hold third set
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hA0, 8'h05, 3'b001, 1'b0);
    tick();
    check("bp_a_data", bus.out_data, 8'hA5);
    check("bp_a_ready", bus.in_ready, 1);
    drive(1'b1, 8'hFF, 8'h0F, 3'b010, 1'b0);
    tick();
    check("bp_full_ready", bus.in_ready, 0);
    drive(1'b1, 8'h0C, 8'h0A, 3'b000, 1'b0);
    tick();
    check("bp_stall1_data", bus.out_data, 8'hA5);
    check("bp_stall1_ready", bus.in_ready, 0);
    tick();
    check("bp_stall2_data", bus.out_data, 8'hA5);
    check("bp_stall_txn", bus.txn_count, 8);
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_data", bus.out_data, 8'hF0);
    check("bp_b_ready", bus.in_ready, 1);
    check("bp_b_txn", bus.txn_count, 9);
    tick();
    check("bp_c_data", bus.out_data, 8'h08);
    check("bp_c_txn", bus.txn_count, 10);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    check("bp_drain_valid", bus.out_valid, 0);
    check("bp_drain_txn", bus.txn_count, 11);

    // asynchronous reset mid-burst
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h00, 3'b001, 1'b0);
    tick();
    tick();
    check("pre_rst_full", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_txn", bus.txn_count, 0);
    check("mid_rst_data", bus.out_data, 0);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h5A, 8'h00, 3'b010, 1'b1);
    tick();
    check("acc_cleared", bus.out_data, 8'h5A);
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    check("post_rst_txn", bus.txn_count, 1);

    // 256 handshakes wrap the counter; illegal ops included
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 8'h00, 3'(i % 8), 1'b0);
      tick();
      check("wrap_err", bus.out_err, ((i % 8) == 7) ? 1 : 0);
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    check("wrap_txn_255", bus.txn_count, 255);
    tick();
    check("wrap_txn_0", bus.txn_count, 0);
    check("wrap_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
